// File: rtl/mouse_tx_pkg.sv
// Shared definitions for the mouse packet transmitter: byte0 layout, frame size,
// sequencer states, packet container and the saturating delta accumulator.
package mouse_tx_pkg;

  localparam int BTN_L      = 0;
  localparam int BTN_R      = 1;
  localparam int BTN_M      = 2;
  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FRAME,
    ST_GAP
  } tx_state_e;

  typedef struct packed {
    logic [7:0] b0;
    logic [7:0] dx;
    logic [7:0] dy;
  } pkt_t;

  // Two's complement add widened to 9 bits, clamped back into [-128, +127].
  function automatic logic [7:0] sat8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {a[7], a} + {b[7], b};
    if (s[8] != s[7]) return s[8] ? 8'h80 : 8'h7F;
    return s[7:0];
  endfunction

  function automatic logic [7:0] pack_buttons(input logic l, input logic r, input logic m);
    logic [7:0] b;
    b        = '0;
    b[BTN_L] = l;
    b[BTN_R] = r;
    b[BTN_M] = m;
    return b;
  endfunction

  function automatic logic [7:0] pkt_byte(input pkt_t p, input logic [1:0] idx);
    case (idx)
      2'd0:    return p.b0;
      2'd1:    return p.dx;
      default: return p.dy;
    endcase
  endfunction

endpackage

// File: rtl/mouse_tx_serializer.sv
// 8N1 byte serializer: a 10-bit frame shifted out LSB first, each bit held DIV clocks.
// frame_done_o is registered and high exactly on the last clock of the stop bit.
module mouse_tx_serializer
  import mouse_tx_pkg::*;
#(
  parameter int DIV = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic [7:0] byte_in_i,
  output logic       tx_o,
  output logic       frame_done_o
);

  localparam int                CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [3:0]        BIT_LAST = 4'(FRAME_BITS - 1);

  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [3:0]            bit_q, bit_d;
  logic                  active_q, active_d;
  logic                  done_q, done_d;

  always_comb begin
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    active_d = active_q;
    if (load_i) begin
      shift_d  = {1'b1, byte_in_i, 1'b0};
      cnt_d    = '0;
      bit_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        // Mark bits fill in behind the frame so the line idles high afterwards.
        shift_d = {1'b1, shift_q[FRAME_BITS-1:1]};
        if (bit_q == BIT_LAST) begin
          active_d = 1'b0;
          bit_d    = '0;
        end else begin
          bit_d = bit_q + 4'd1;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    done_d = active_d && (bit_d == BIT_LAST) && (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q  <= '1;
      cnt_q    <= '0;
      bit_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign tx_o         = shift_q[0];
  assign frame_done_o = done_q;

endmodule

// File: rtl/mouse_tx.sv
// Mouse packet transmitter: sequences buttons/dx/dy bytes over 8N1 with optional
// inter-byte gaps, coalescing requests made while busy into one pending packet.
module mouse_tx
  import mouse_tx_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600,
  parameter int GAP_BITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_middle,
  input  logic [7:0] delta_x,
  input  logic [7:0] delta_y,
  input  logic       send,
  output logic       tx_pin,
  output logic       busy,
  output logic       done
);

  localparam int               DIV      = CLK_FREQ / BAUD;
  localparam int               GAP_CYC  = GAP_BITS * DIV;
  localparam int               GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  tx_state_e        state_q;
  pkt_t             act_q, pend_q, pend_d, in_pkt;
  logic             pend_valid_q, pend_valid_d;
  logic [1:0]       byte_idx_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic             busy_q;
  logic             load;
  logic [7:0]       load_byte;
  logic             ser_done, frame_last, last_byte;

  mouse_tx_serializer #(.DIV(DIV)) u_ser (
    .clk          (clk),
    .reset        (reset),
    .load_i       (load),
    .byte_in_i    (load_byte),
    .tx_o         (tx_pin),
    .frame_done_o (ser_done)
  );

  assign frame_last = ser_done && (state_q == ST_FRAME);
  assign last_byte  = (byte_idx_q == 2'd2);

  always_comb begin
    in_pkt       = '{b0: pack_buttons(btn_left, btn_right, btn_middle), dx: delta_x, dy: delta_y};
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    // Any non-idle state, the final stop cycle included, merges into pending.
    if (send && (state_q != ST_IDLE)) begin
      pend_valid_d = 1'b1;
      if (pend_valid_q) begin
        pend_d.b0 = in_pkt.b0;
        pend_d.dx = sat8(pend_q.dx, delta_x);
        pend_d.dy = sat8(pend_q.dy, delta_y);
      end else begin
        pend_d = in_pkt;
      end
    end

    load      = 1'b0;
    load_byte = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (send) begin
          load      = 1'b1;
          load_byte = in_pkt.b0;
        end
      end
      ST_FRAME: begin
        if (frame_last) begin
          if (last_byte) begin
            if (pend_valid_d) begin
              load      = 1'b1;
              load_byte = pend_d.b0;
            end
          end else if (GAP_CYC == 0) begin
            load      = 1'b1;
            load_byte = pkt_byte(act_q, byte_idx_q + 2'd1);
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          load      = 1'b1;
          load_byte = pkt_byte(act_q, byte_idx_q + 2'd1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      act_q        <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      byte_idx_q   <= '0;
      gap_cnt_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      case (state_q)
        ST_IDLE: begin
          if (send) begin
            act_q      <= in_pkt;
            byte_idx_q <= 2'd0;
            busy_q     <= 1'b1;
            state_q    <= ST_FRAME;
          end
        end
        ST_FRAME: begin
          if (frame_last) begin
            if (last_byte) begin
              if (pend_valid_d) begin
                act_q        <= pend_d;
                pend_valid_q <= 1'b0;
                byte_idx_q   <= 2'd0;
              end else begin
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
              end
            end else if (GAP_CYC == 0) begin
              byte_idx_q <= byte_idx_q + 2'd1;
            end else begin
              gap_cnt_q <= '0;
              state_q   <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            byte_idx_q <= byte_idx_q + 2'd1;
            state_q    <= ST_FRAME;
          end else begin
            gap_cnt_q <= gap_cnt_q + GAP_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign done = frame_last && last_byte;
  // busy drops within the final stop cycle unless a packet is queued, counting a send made right then.
  assign busy = busy_q && !(done && !pend_valid_d);

endmodule

// File: tb/tb_mouse_tx.sv
// Randomized self-checking bench for mouse_tx: a schedule-level packet model predicts
// busy/done per cycle and the packets a line decoder recovers from tx_pin.
module tb_mouse_tx;

  localparam int CLK_FREQ = 800;
  localparam int BAUD     = 100;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int GAP      = 1;
  localparam int T        = (30 + 2 * GAP) * DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       bl = 1'b0, br = 1'b0, bm = 1'b0;
  logic [7:0] dx = '0, dy = '0;
  logic       send = 1'b0, send_g = 1'b0;
  logic       tx_pin, busy, done;
  logic       tx_g0, busy_g0, done_g0;
  logic       tx_g3, busy_g3, done_g3;

  always #5 clk = ~clk;

  mouse_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .GAP_BITS(GAP)) dut (
    .clk(clk), .reset(reset), .btn_left(bl), .btn_right(br), .btn_middle(bm),
    .delta_x(dx), .delta_y(dy), .send(send), .tx_pin(tx_pin), .busy(busy), .done(done));
  mouse_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .GAP_BITS(0)) dut_g0 (
    .clk(clk), .reset(reset), .btn_left(bl), .btn_right(br), .btn_middle(bm),
    .delta_x(dx), .delta_y(dy), .send(send_g), .tx_pin(tx_g0), .busy(busy_g0), .done(done_g0));
  mouse_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .GAP_BITS(3)) dut_g3 (
    .clk(clk), .reset(reset), .btn_left(bl), .btn_right(br), .btn_middle(bm),
    .delta_x(dx), .delta_y(dy), .send(send_g), .tx_pin(tx_g3), .busy(busy_g3), .done(done_g3));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: a packet occupies cycles [m_start, m_end]; requests within that
  // window accumulate into one pending packet that launches right after m_end.
  int          m_start = 0, m_end = -1, m_pushes = 0, m_aborted = 0;
  bit          m_pv = 1'b0;
  logic [23:0] m_pend = '0;
  logic [23:0] exp_q[$];
  int          exp_st_q[$];
  logic        tx_s, busy_s, done_s;

  function automatic logic [7:0] sat(input logic [7:0] a, input logic [7:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
    return 8'(s);
  endfunction

  task automatic launch(input logic [23:0] p, input int start);
    exp_q.push_back(p);
    exp_st_q.push_back(start);
    m_start = start;
    m_end   = start + T - 1;
    m_pushes++;
  endtask

  task automatic tick(input bit snd, input logic [2:0] b, input logic [7:0] x, input logic [7:0] y);
    bit          exp_busy, exp_done;
    logic [23:0] p;
    send = snd; bl = b[0]; br = b[1]; bm = b[2]; dx = x; dy = y;
    p = {5'b0, b, x, y};
    if (snd) begin
      if (cyc >= m_start && cyc <= m_end) begin
        if (m_pv) m_pend = {p[23:16], sat(m_pend[15:8], x), sat(m_pend[7:0], y)};
        else      m_pend = p;
        m_pv = 1'b1;
      end else begin
        launch(p, cyc + 1);
      end
    end
    exp_done = (cyc == m_end);
    exp_busy = (cyc >= m_start && cyc < m_end) || (exp_done && m_pv);
    if (exp_done && m_pv) begin
      launch(m_pend, cyc + 1);
      m_pv = 1'b0;
    end
    @(negedge clk);
    check("busy", busy, exp_busy);
    check("done", done, exp_done);
    tx_s = tx_pin; busy_s = busy; done_s = done;
    @(posedge clk); #1;
    send = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2 * T + 10 && cyc <= m_end; i++) tick(1'b0, 3'b0, 8'h00, 8'h00);
    repeat (2) tick(1'b0, 3'b0, 8'h00, 8'h00);
    check("idle_reached", cyc > m_end, 1);
    check("exp_queue_drained", exp_q.size(), 0);
  endtask

  // Line decoder: samples mid-bit, assembles bytes into 3-byte packets.
  int          mon_cnt = 0, mon_nb = 0, mon_st = 0, rx_count = 0;
  bit          mon_act = 1'b0;
  logic [7:0]  mon_byte = '0;
  logic [23:0] mon_pkt = '0, last_rx = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_act = 1'b0;
        mon_nb  = 0;
      end else begin
        if (!mon_act) begin
          if (tx_pin === 1'b0) begin
            mon_act = 1'b1;
            mon_cnt = 0;
            if (mon_nb == 0) mon_st = cyc;
          end
        end else begin
          mon_cnt++;
        end
        if (mon_act && (mon_cnt % DIV) == DIV / 2) begin
          int k;
          k = mon_cnt / DIV;
          if (k == 0) check("rx_start_bit", tx_pin, 0);
          else if (k <= 8) mon_byte[k-1] = tx_pin;
          else begin
            check("rx_stop_bit", tx_pin, 1);
            mon_act = 1'b0;
            mon_pkt = {mon_pkt[15:0], mon_byte};
            mon_nb++;
            if (mon_nb == 3) begin
              mon_nb = 0;
              rx_count++;
              last_rx = mon_pkt;
              $display("rx packet %0d: b0=%02h dx=%02h dy=%02h start=%0d", rx_count,
                       mon_pkt[23:16], mon_pkt[15:8], mon_pkt[7:0], mon_st);
              check("rx_expected_pending", exp_q.size() > 0, 1);
              if (exp_q.size() > 0) begin
                check("rx_packet", mon_pkt, exp_q.pop_front());
                check("rx_start_cycle", mon_st, exp_st_q.pop_front());
              end
            end
          end
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t1b[3];
    bit         lv[$];
    int         mism, dones, low, s, rc0;
    int         f0, f3, d0, d3;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx_pin, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: L+M, dx=0x10, dy=0xF0, exact bit-level waveform
    t1b = '{8'h05, 8'h10, 8'hF0};
    for (int j = 0; j < 3; j++) begin
      lv.push_back(1'b0);
      for (int k = 0; k < 8; k++) lv.push_back(t1b[j][k]);
      lv.push_back(1'b1);
      if (j < 2) for (int g = 0; g < GAP; g++) lv.push_back(1'b1);
    end
    tick(1'b1, 3'b101, 8'h10, 8'hF0);
    mism = 0; dones = 0;
    for (int i = 0; i < T; i++) begin
      tick(1'b0, 3'b0, 8'h00, 8'h00);
      if (tx_s !== lv[i / DIV]) mism++;
      if (done_s === 1'b1) dones++;
    end
    check("t1_waveform_mismatches", mism, 0);
    check("t1_done_count", dones, 1);
    wait_idle();
    check("t1_busy_after", busy, 0);
    check("t1_rx", last_rx, 24'h0510F0);

    // 2: coalescing with saturation in both directions
    tick(1'b1, 3'b001, 8'h00, 8'h00);
    repeat (50) tick(1'b0, 3'b0, 8'h00, 8'h00);
    tick(1'b1, 3'b010, 8'd100, 8'h9C);
    repeat (20) tick(1'b0, 3'b0, 8'h00, 8'h00);
    tick(1'b1, 3'b100, 8'd100, 8'h9C);
    wait_idle();
    check("t2_rx_saturated", last_rx, 24'h047F80);

    // 3: send on the done cycle chains one packet with no busy gap
    rc0 = rx_count;
    tick(1'b1, 3'b011, 8'h05, 8'h07);
    for (int i = 0; i < T && cyc < m_end; i++) tick(1'b0, 3'b0, 8'h00, 8'h00);
    check("t3_at_done_cycle", cyc, m_end);
    tick(1'b1, 3'b101, 8'hFE, 8'h02);
    low = 0;
    for (int i = 0; i < T - 1; i++) begin
      tick(1'b0, 3'b0, 8'h00, 8'h00);
      if (busy_s !== 1'b1) low++;
    end
    check("t3_busy_low_cycles", low, 0);
    wait_idle();
    check("t3_packets", rx_count - rc0, 2);
    check("t3_rx", last_rx, 24'h05FE02);

    // 4: reset during byte1 data bits
    s = cyc;
    tick(1'b1, 3'b010, 8'h33, 8'h44);
    while (cyc < s + 1 + (10 + GAP + 1 + 3) * DIV) tick(1'b0, 3'b0, 8'h00, 8'h00);
    check("t4_tx_before_reset", tx_pin, 0);
    reset = 1'b1;
    #1;
    check("t4_tx_async", tx_pin, 1);
    check("t4_busy", busy, 0);
    check("t4_done", done, 0);
    m_aborted += exp_q.size();
    exp_q.delete(); exp_st_q.delete();
    m_pv = 1'b0; m_start = 0; m_end = -1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) tick(1'b0, 3'b0, 8'h00, 8'h00);
    tick(1'b1, 3'b111, 8'h81, 8'h7E);
    wait_idle();
    check("t4_clean_packet", last_rx, 24'h07817E);

    // 5: packet duration for GAP_BITS=0 and GAP_BITS=3
    f0 = -1; f3 = -1; d0 = -1; d3 = -1;
    send_g = 1'b1;
    @(posedge clk); #1;
    send_g = 1'b0;
    for (int i = 0; i < 2000 && (d0 < 0 || d3 < 0); i++) begin
      @(negedge clk);
      if (f0 < 0 && tx_g0 === 1'b0) f0 = cyc;
      if (f3 < 0 && tx_g3 === 1'b0) f3 = cyc;
      if (d0 < 0 && done_g0 === 1'b1) d0 = cyc;
      if (d3 < 0 && done_g3 === 1'b1) d3 = cyc;
    end
    check("t5_duration_gap0", d0 - f0 + 1, 30 * DIV);
    check("t5_duration_gap3", d3 - f3 + 1, 36 * DIV);
    @(posedge clk); #1;
    check("t5_gap_busy_after", {busy_g0, busy_g3}, 2'b00);

    // 6: random requests, including many that coalesce
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 350)) tick(1'b0, 3'b0, 8'h00, 8'h00);
    end
    wait_idle();
    check("t6_packet_total", rx_count, m_pushes - m_aborted);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
